div_sequencer: RTL

DIV_SEQUENCER -- requirements
Module: div_sequencer

---
 rtl/div_pkg.sv | 31 +++
 rtl/div_req_fifo.sv | 68 ++++++
 rtl/div_sequencer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types for the divider request sequencer: FSM states, result record,
// default operand width and the divide-by-zero result helper.
package div_pkg;

   localparam int unsigned DIV_DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_WAIT,
      ST_HOLD
   } div_state_e;

   typedef struct packed {
      logic [DIV_DATA_W-1:0] quotient;
      logic [DIV_DATA_W-1:0] remainder;
      logic                  dbz;
      logic                  timeout;
   } div_result_t;

   // Divide by zero mirrors the RISC-V convention: all-ones quotient, dividend as remainder.
   function automatic div_result_t dbz_result(input logic [DIV_DATA_W-1:0] dividend);
      div_result_t r;
      r.quotient  = '1;
      r.remainder = dividend;
      r.dbz       = 1'b1;
      r.timeout   = 1'b0;
      return r;
   endfunction

endpackage

// File: rtl/div_req_fifo.sv
// Request queue for the divider sequencer. Full/empty are registered, so a
// push into an empty queue is never visible to the reader in the same cycle.
module div_req_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_full,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;
   logic             full_q;
   logic             empty_q;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok = i_push & ~full_q;
   assign pop_ok  = i_pop & ~empty_q;

   always_comb begin
      count_d = count_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= i_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
         full_q  <= (count_d == CW'(DEPTH));
         empty_q <= (count_d == '0);
      end
   end

   assign o_data  = mem_q[rd_ptr_q];
   assign o_full  = full_q;
   assign o_empty = empty_q;

endmodule

// File: rtl/div_sequencer.sv
// Queues divide requests and feeds them one at a time to an iterative divider,
// handling divide-by-zero locally and bounding each divide with a timeout.
module div_sequencer
   import div_pkg::*;
#(
   parameter int unsigned DATA_W      = DIV_DATA_W,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic [DATA_W-1:0] i_req_dividend,
   input  logic [DATA_W-1:0] i_req_divisor,
   output logic              o_div_start,
   output logic [DATA_W-1:0] o_div_dividend,
   output logic [DATA_W-1:0] o_div_divisor,
   input  logic [DATA_W-1:0] i_div_quotient,
   input  logic [DATA_W-1:0] i_div_remainder,
   input  logic              i_div_finish,
   output logic              o_res_valid,
   input  logic              i_res_ready,
   output logic [DATA_W-1:0] o_res_quotient,
   output logic [DATA_W-1:0] o_res_remainder,
   output logic              o_res_dbz,
   output logic              o_res_timeout
);

   localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

   div_state_e          state_q;
   logic [TW-1:0]       tmo_cnt_q;
   logic                start_q;
   logic                res_valid_q;
   div_result_t         res_q;
   logic [DATA_W-1:0]   opa_q;
   logic [DATA_W-1:0]   opb_q;

   logic                fifo_full;
   logic                fifo_empty;
   logic                fifo_pop;
   logic [2*DATA_W-1:0] fifo_rd_data;
   logic [DATA_W-1:0]   head_dividend;
   logic [DATA_W-1:0]   head_divisor;

   div_req_fifo #(
      .WIDTH (2 * DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (i_req_valid),
      .i_data  ({i_req_dividend, i_req_divisor}),
      .o_full  (fifo_full),
      .i_pop   (fifo_pop),
      .o_data  (fifo_rd_data),
      .o_empty (fifo_empty)
   );

   assign head_dividend = fifo_rd_data[2*DATA_W-1:DATA_W];
   assign head_divisor  = fifo_rd_data[DATA_W-1:0];
   assign fifo_pop      = (state_q == ST_IDLE) && !fifo_empty;

   // Finish and result-ready are only looked at in WAIT and HOLD; elsewhere they are ignored.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         tmo_cnt_q   <= '0;
         start_q     <= 1'b0;
         res_valid_q <= 1'b0;
         res_q       <= '0;
         opa_q       <= '0;
         opb_q       <= '0;
      end else begin
         start_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  opa_q <= head_dividend;
                  opb_q <= head_divisor;
                  if (head_divisor == '0) begin
                     res_q       <= dbz_result(head_dividend);
                     res_valid_q <= 1'b1;
                     state_q     <= ST_HOLD;
                  end else begin
                     start_q <= 1'b1;
                     state_q <= ST_START;
                  end
               end
            end
            ST_START: begin
               tmo_cnt_q <= '0;
               state_q   <= ST_WAIT;
            end
            ST_WAIT: begin
               if (i_div_finish) begin
                  res_q       <= '{quotient: i_div_quotient, remainder: i_div_remainder,
                                   dbz: 1'b0, timeout: 1'b0};
                  res_valid_q <= 1'b1;
                  state_q     <= ST_HOLD;
               end else if (tmo_cnt_q == TMO_LAST) begin
                  res_q       <= '{quotient: '0, remainder: '0, dbz: 1'b0, timeout: 1'b1};
                  res_valid_q <= 1'b1;
                  state_q     <= ST_HOLD;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
               end
            end
            ST_HOLD: begin
               if (i_res_ready) begin
                  res_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign o_req_ready     = !fifo_full;
   assign o_div_start     = start_q;
   assign o_div_dividend  = opa_q;
   assign o_div_divisor   = opb_q;
   assign o_res_valid     = res_valid_q;
   assign o_res_quotient  = res_q.quotient;
   assign o_res_remainder = res_q.remainder;
   assign o_res_dbz       = res_q.dbz;
   assign o_res_timeout   = res_q.timeout;

endmodule
